// File: rtl/array_wrport_ctrl_if.sv
// Write-port bundle between the array write controller and its clients:
// datapath/CPU requests, parity control, and the array write bus.
interface array_wrport_ctrl_if #(
    parameter int ADDRBIT = 9,
    parameter int WIDTH   = 32
);
    logic               init_start, init_busy, init_done;
    logic               dp_we, dp_drop;
    logic [ADDRBIT-1:0] dp_wa;
    logic [WIDTH-1:0]   dp_di;
    logic               cpu_req, cpu_ack, cpu_aerr, cpu_pardis, cpu_parclr;
    logic [ADDRBIT-1:0] cpu_wa;
    logic [WIDTH-1:0]   cpu_di;
    logic               par_err, par_int;
    logic               we;
    logic [ADDRBIT-1:0] wa;
    logic [WIDTH-1:0]   di;
    logic [1:0]         par_ctrl;

    modport master (
        output init_start, dp_we, dp_wa, dp_di, cpu_req, cpu_wa, cpu_di,
               cpu_pardis, cpu_parclr, par_err,
        input  init_busy, init_done, dp_drop, cpu_ack, cpu_aerr, par_int,
               we, wa, di, par_ctrl
    );

    modport slave (
        input  init_start, dp_we, dp_wa, dp_di, cpu_req, cpu_wa, cpu_di,
               cpu_pardis, cpu_parclr, par_err,
        output init_busy, init_done, dp_drop, cpu_ack, cpu_aerr, par_int,
               we, wa, di, par_ctrl
    );
endinterface

// File: rtl/array_wrport_ctrl.sv
// Write-port controller for the parity register array: init sweep, dp/CPU
// arbitration with a one-entry dp skid and CPU starvation guard, parity control.
module array_wrport_ctrl #(
    parameter int               ADDRBIT = 9,
    parameter int               DEPTH   = 512,
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] INITVAL = '0,
    parameter int               STARVE  = 8
) (
    input  logic             clk,
    input  logic             rst,
    array_wrport_ctrl_if.slave bus
);
    localparam logic [ADDRBIT-1:0] LAST_A   = ADDRBIT'(DEPTH - 1);
    localparam logic [ADDRBIT:0]   DEPTH_W  = (ADDRBIT + 1)'(DEPTH);
    localparam int                 SW       = $clog2(STARVE + 1);
    localparam logic [SW-1:0]      STARVE_W = SW'(STARVE);

    // INIT encodes as 0 so the reset state is already the sweep start
    typedef enum logic {ST_INIT = 1'b0, ST_NORM = 1'b1} state_t;

    state_t             state, state_n;
    logic [ADDRBIT-1:0] cnt, cnt_n;
    logic               skid_vld, skid_vld_n;
    logic [ADDRBIT-1:0] skid_wa, skid_wa_n;
    logic [WIDTH-1:0]   skid_di, skid_di_n;
    logic [SW-1:0]      starve, starve_n;
    logic [2:0]         post_cnt, guard;

    logic               busy_q, done_q, drop_q, ack_q, aerr_q, int_q, we_q;
    logic [ADDRBIT-1:0] wa_q;
    logic [WIDTH-1:0]   di_q;
    logic [1:0]         pctl_q;

    logic               sel_we, done_n, ack_n, aerr_n, drop_set, grant, skid_load;
    logic [ADDRBIT-1:0] sel_wa;
    logic [WIDTH-1:0]   sel_di;
    logic               cpu_ok, cpu_oob;

    // A request still high in its ack cycle is the old one; ignore it
    assign cpu_ok  = bus.cpu_req && !ack_q;
    assign cpu_oob = {1'b0, bus.cpu_wa} >= DEPTH_W;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        skid_vld_n = skid_vld;
        skid_wa_n  = skid_wa;
        skid_di_n  = skid_di;
        starve_n   = starve;
        sel_we     = 1'b0;
        sel_wa     = '0;
        sel_di     = '0;
        done_n     = 1'b0;
        ack_n      = 1'b0;
        aerr_n     = 1'b0;
        drop_set   = 1'b0;
        grant      = 1'b0;
        skid_load  = 1'b0;
        case (state)
            ST_INIT: begin
                sel_we   = 1'b1;
                sel_wa   = cnt;
                sel_di   = INITVAL;
                drop_set = bus.dp_we;
                if (cnt == LAST_A) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = ST_NORM;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_NORM: begin
                if (bus.init_start) begin
                    state_n    = ST_INIT;
                    skid_vld_n = 1'b0;
                    drop_set   = skid_vld | bus.dp_we;
                end else if (skid_vld) begin
                    sel_we     = 1'b1;
                    sel_wa     = skid_wa;
                    sel_di     = skid_di;
                    skid_vld_n = 1'b0;
                    skid_load  = bus.dp_we;
                end else if (cpu_ok && starve == STARVE_W) begin
                    grant     = 1'b1;
                    skid_load = bus.dp_we;
                end else if (bus.dp_we) begin
                    sel_we = 1'b1;
                    sel_wa = bus.dp_wa;
                    sel_di = bus.dp_di;
                end else if (cpu_ok) begin
                    grant = 1'b1;
                end
            end
            default: ;
        endcase
        if (skid_load) begin
            skid_vld_n = 1'b1;
            skid_wa_n  = bus.dp_wa;
            skid_di_n  = bus.dp_di;
        end
        if (grant) begin
            ack_n    = 1'b1;
            aerr_n   = cpu_oob;
            sel_we   = !cpu_oob;
            sel_wa   = bus.cpu_wa;
            sel_di   = bus.cpu_di;
            starve_n = '0;
        end else if (cpu_ok && starve != STARVE_W) begin
            starve_n = starve + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            skid_vld <= 1'b0;
            skid_wa  <= '0;
            skid_di  <= '0;
            starve   <= '0;
            post_cnt <= '0;
            guard    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            ack_q    <= 1'b0;
            aerr_q   <= 1'b0;
            int_q    <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            di_q     <= '0;
            pctl_q   <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            skid_vld <= skid_vld_n;
            skid_wa  <= skid_wa_n;
            skid_di  <= skid_di_n;
            starve   <= starve_n;
            busy_q   <= (state == ST_INIT);
            done_q   <= done_n;
            ack_q    <= ack_n;
            aerr_q   <= aerr_n;
            we_q     <= sel_we;
            wa_q     <= sel_wa;
            di_q     <= sel_di;
            drop_q   <= drop_set | (drop_q & ~bus.cpu_parclr);
            post_cnt <= done_n ? 3'd4 : (post_cnt != 3'd0 ? post_cnt - 3'd1 : 3'd0);
            // Guard masks the array's stale sticky par_err until its clear lands
            guard    <= (bus.cpu_parclr || done_n) ? 3'd6
                      : (guard != 3'd0 ? guard - 3'd1 : 3'd0);
            if (bus.cpu_parclr)
                int_q <= 1'b0;
            else if (bus.par_err && guard == 3'd0)
                int_q <= 1'b1;
            pctl_q[1] <= bus.cpu_pardis;
            pctl_q[0] <= bus.cpu_parclr | (state == ST_INIT) | (post_cnt != 3'd0);
        end
    end

    assign bus.init_busy = busy_q;
    assign bus.init_done = done_q;
    assign bus.dp_drop   = drop_q;
    assign bus.cpu_ack   = ack_q;
    assign bus.cpu_aerr  = aerr_q;
    assign bus.par_int   = int_q;
    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.di        = di_q;
    assign bus.par_ctrl  = pctl_q;
endmodule

// File: tb/tb_array_wrport_ctrl.sv
// Directed bench for array_wrport_ctrl with DEPTH=8, STARVE=8.
module tb_array_wrport_ctrl;
    localparam int          AB    = 4;
    localparam int          W     = 16;
    localparam logic [15:0] INITV = 16'h00A5;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    array_wrport_ctrl_if #(.ADDRBIT(AB), .WIDTH(W)) bus ();

    array_wrport_ctrl #(
        .ADDRBIT(AB), .DEPTH(8), .WIDTH(W), .INITVAL(INITV), .STARVE(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.init_start = 0; bus.dp_we = 0; bus.dp_wa = '0; bus.dp_di = '0;
        bus.cpu_req = 0; bus.cpu_wa = '0; bus.cpu_di = '0;
        bus.cpu_pardis = 0; bus.cpu_parclr = 0; bus.par_err = 0;
        repeat (3) tick();
        n_cmp++;
        if ({bus.init_busy, bus.init_done, bus.we, bus.wa, bus.di, bus.cpu_ack, bus.cpu_aerr,
             bus.dp_drop, bus.par_int, bus.par_ctrl} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b we=%b wa=%h di=%h ack=%b pctl=%b want all 0",
                     bus.init_busy, bus.we, bus.wa, bus.di, bus.cpu_ack, bus.par_ctrl);
        end
        rst = 1'b0;
    endtask

    task automatic test_init;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({bus.init_busy, bus.we, bus.wa, bus.di, bus.init_done, bus.par_ctrl[0]} !==
                {1'b1, 1'b1, 4'(i), INITV, (i == 7), 1'b1}) begin
                n_err++;
                $display("FAIL init_write i=%0d got busy=%b we=%b wa=%0d di=%h done=%b pc0=%b want 1 1 %0d %h %b 1",
                         i, bus.init_busy, bus.we, bus.wa, bus.di, bus.init_done, bus.par_ctrl[0],
                         i, INITV, (i == 7));
            end
            if (i == 3) begin
                bus.dp_we = 1'b1; bus.dp_wa = 4'd3; bus.dp_di = 16'hDEAD;
            end
            if (i == 4) begin
                bus.dp_we = 1'b0;
                n_cmp++;
                if (bus.dp_drop !== 1'b1) begin
                    n_err++;
                    $display("FAIL init_dp_drop got %b want 1", bus.dp_drop);
                end
            end
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({bus.init_busy, bus.we, bus.par_ctrl[0]} !== {1'b0, 1'b0, (k <= 4)}) begin
                n_err++;
                $display("FAIL post_init k=%0d got busy=%b we=%b pc0=%b want 0 0 %b",
                         k, bus.init_busy, bus.we, bus.par_ctrl[0], (k <= 4));
            end
        end
        bus.cpu_parclr = 1'b1;
        tick();
        bus.cpu_parclr = 1'b0;
        n_cmp++;
        if ({bus.dp_drop, bus.par_ctrl[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL parclr_drop got drop=%b pc0=%b want 0 1", bus.dp_drop, bus.par_ctrl[0]);
        end
        tick();
        n_cmp++;
        if (bus.par_ctrl[0] !== 1'b0) begin
            n_err++;
            $display("FAIL parclr_pulse got pc0=%b want 0", bus.par_ctrl[0]);
        end
    endtask

    // dp write j every cycle, CPU held: forced grant on cycle 9, dp 9 follows from skid
    task automatic test_starve;
        logic [21:0] exp;
        for (int j = 1; j <= 14; j++) begin
            bus.dp_we   = (j <= 12);
            bus.dp_wa   = 4'(j & 7);
            bus.dp_di   = 16'(256 + j);
            bus.cpu_req = (j <= 9);
            bus.cpu_wa  = 4'd5;
            bus.cpu_di  = 16'hC0DE;
            tick();
            if (j <= 8)       exp = {1'b1, 4'(j & 7), 16'(256 + j), 1'b0};
            else if (j == 9)  exp = {1'b1, 4'd5, 16'hC0DE, 1'b1};
            else if (j <= 13) exp = {1'b1, 4'((j - 1) & 7), 16'(256 + j - 1), 1'b0};
            else              exp = {1'b0, bus.wa, bus.di, 1'b0};
            n_cmp++;
            if ({bus.we, bus.wa, bus.di, bus.cpu_ack} !== exp) begin
                n_err++;
                $display("FAIL starve_seq j=%0d got we=%b wa=%0d di=%h ack=%b want %h",
                         j, bus.we, bus.wa, bus.di, bus.cpu_ack, exp);
            end
        end
        bus.dp_we = 1'b0;
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_aerr;
        bus.cpu_req = 1'b1; bus.cpu_wa = 4'd8; bus.cpu_di = 16'h1111;
        tick();
        n_cmp++;
        if ({bus.we, bus.cpu_ack, bus.cpu_aerr} !== 3'b011) begin
            n_err++;
            $display("FAIL cpu_aerr got we=%b ack=%b aerr=%b want 0 1 1", bus.we, bus.cpu_ack, bus.cpu_aerr);
        end
        bus.cpu_wa = 4'd2; bus.cpu_di = 16'hBEEF;
        tick();
        n_cmp++;
        if ({bus.we, bus.cpu_ack, bus.cpu_aerr} !== 3'b000) begin
            n_err++;
            $display("FAIL cpu_ack_gap got we=%b ack=%b aerr=%b want 0 0 0", bus.we, bus.cpu_ack, bus.cpu_aerr);
        end
        tick();
        bus.cpu_req = 1'b0;
        n_cmp++;
        if ({bus.we, bus.wa, bus.di, bus.cpu_ack, bus.cpu_aerr} !== {1'b1, 4'd2, 16'hBEEF, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL cpu_write got we=%b wa=%0d di=%h ack=%b aerr=%b want 1 2 beef 1 0",
                     bus.we, bus.wa, bus.di, bus.cpu_ack, bus.cpu_aerr);
        end
        bus.dp_we = 1'b1; bus.dp_wa = 4'd9; bus.dp_di = 16'h1234;
        tick();
        bus.dp_we = 1'b0;
        n_cmp++;
        if ({bus.we, bus.wa, bus.di, bus.cpu_ack} !== {1'b1, 4'd9, 16'h1234, 1'b0}) begin
            n_err++;
            $display("FAIL dp_oob_write got we=%b wa=%0d di=%h ack=%b want 1 9 1234 0",
                     bus.we, bus.wa, bus.di, bus.cpu_ack);
        end
        tick();
        n_cmp++;
        if (bus.we !== 1'b0) begin
            n_err++;
            $display("FAIL idle_we got %b want 0", bus.we);
        end
    endtask

    task automatic test_parity;
        bus.par_err = 1'b1;
        tick();
        n_cmp++;
        if (bus.par_int !== 1'b1) begin
            n_err++;
            $display("FAIL par_int_set got %b want 1", bus.par_int);
        end
        bus.cpu_parclr = 1'b1;
        tick();
        bus.cpu_parclr = 1'b0;
        n_cmp++;
        if ({bus.par_int, bus.par_ctrl[0]} !== 2'b01) begin
            n_err++;
            $display("FAIL par_clr got int=%b pc0=%b want 0 1", bus.par_int, bus.par_ctrl[0]);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++;
            if ({bus.par_int, bus.par_ctrl[0]} !== 2'b00) begin
                n_err++;
                $display("FAIL par_guard k=%0d got int=%b pc0=%b want 0 0", k, bus.par_int, bus.par_ctrl[0]);
            end
        end
        bus.par_err = 1'b0;
        bus.cpu_pardis = 1'b1;
        tick();
        bus.cpu_pardis = 1'b0;
        n_cmp++;
        if (bus.par_ctrl !== 2'b10) begin
            n_err++;
            $display("FAIL par_dis got %b want 10", bus.par_ctrl);
        end
    endtask

    // Skid holds dp 10 when init_start hits; CPU request B waits through INIT
    task automatic test_reinit;
        for (int j = 1; j <= 20; j++) begin
            bus.dp_we      = (j <= 10);
            bus.dp_wa      = 4'(j & 7);
            bus.dp_di      = 16'(256 + j);
            bus.cpu_req    = 1'b1;
            bus.cpu_wa     = (j <= 9) ? 4'd5 : 4'd6;
            bus.cpu_di     = (j <= 9) ? 16'hC0DE : 16'hB0B0;
            bus.init_start = (j == 11);
            tick();
            n_cmp++;
            if (j <= 8) begin
                if ({bus.we, bus.wa, bus.di, bus.cpu_ack} !== {1'b1, 4'(j & 7), 16'(256 + j), 1'b0}) begin
                    n_err++;
                    $display("FAIL reinit_dp j=%0d got we=%b wa=%0d di=%h ack=%b", j, bus.we, bus.wa, bus.di, bus.cpu_ack);
                end
            end else if (j == 9) begin
                if ({bus.we, bus.wa, bus.cpu_ack} !== {1'b1, 4'd5, 1'b1}) begin
                    n_err++;
                    $display("FAIL reinit_cpuA got we=%b wa=%0d ack=%b want 1 5 1", bus.we, bus.wa, bus.cpu_ack);
                end
            end else if (j == 10) begin
                if ({bus.we, bus.wa, bus.di, bus.cpu_ack} !== {1'b1, 4'd1, 16'd265, 1'b0}) begin
                    n_err++;
                    $display("FAIL reinit_skid got we=%b wa=%0d di=%h ack=%b want 1 1 0109 0", bus.we, bus.wa, bus.di, bus.cpu_ack);
                end
            end else if (j == 11) begin
                if ({bus.we, bus.cpu_ack, bus.dp_drop} !== 3'b001) begin
                    n_err++;
                    $display("FAIL reinit_flush got we=%b ack=%b drop=%b want 0 0 1", bus.we, bus.cpu_ack, bus.dp_drop);
                end
            end else if (j <= 19) begin
                if ({bus.init_busy, bus.we, bus.wa, bus.cpu_ack, bus.init_done} !==
                    {1'b1, 1'b1, 4'(j - 12), 1'b0, (j == 19)}) begin
                    n_err++;
                    $display("FAIL reinit_sweep j=%0d got busy=%b we=%b wa=%0d ack=%b done=%b",
                             j, bus.init_busy, bus.we, bus.wa, bus.cpu_ack, bus.init_done);
                end
            end else begin
                if ({bus.we, bus.wa, bus.di, bus.cpu_ack, bus.init_busy} !== {1'b1, 4'd6, 16'hB0B0, 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL reinit_cpuB got we=%b wa=%0d di=%h ack=%b busy=%b want 1 6 b0b0 1 0",
                             bus.we, bus.wa, bus.di, bus.cpu_ack, bus.init_busy);
                end
            end
        end
        bus.cpu_req = 1'b0;
        bus.init_start = 1'b0;
        tick();
    endtask

    task automatic test_rst_mid_init;
        bus.init_start = 1'b1;
        tick();
        bus.init_start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({bus.init_busy, bus.we, bus.wa} !== {1'b1, 1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL midinit_wa got busy=%b we=%b wa=%0d want 1 1 1", bus.init_busy, bus.we, bus.wa);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.init_busy, bus.we, bus.wa, bus.dp_drop, bus.par_ctrl} !== '0) begin
            n_err++;
            $display("FAIL midinit_rst got busy=%b we=%b wa=%0d drop=%b pctl=%b want 0",
                     bus.init_busy, bus.we, bus.wa, bus.dp_drop, bus.par_ctrl);
        end
        tick();
        n_cmp++;
        if ({bus.init_busy, bus.we, bus.wa} !== {1'b1, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL midinit_restart got busy=%b we=%b wa=%0d want 1 1 0", bus.init_busy, bus.we, bus.wa);
        end
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_init();
        test_starve();
        test_aerr();
        test_parity();
        test_reinit();
        test_rst_mid_init();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
